// File: rtl/dplca_txop_select_if.sv
// Bundle between the TXOP claim table / PLCA control side and the TXOP selector.
// The slave modport is the selector; master is the aging/control side driving it.
interface dplca_txop_select_if;
    logic         dplca_en;
    logic         dplca_txop_table_upd;
    logic [511:0] txop_claim_table_unpacked;
    logic [7:0]   max_id;
    logic         dplca_conflict;
    logic [7:0]   local_nodeID;
    logic [1:0]   dplca_txop_claim;
    logic [2:0]   sel_state;
    logic         scan_fail;

    modport master (
        output dplca_en,
        output dplca_txop_table_upd,
        output txop_claim_table_unpacked,
        output max_id,
        output dplca_conflict,
        input  local_nodeID,
        input  dplca_txop_claim,
        input  sel_state,
        input  scan_fail
    );

    modport slave (
        input  dplca_en,
        input  dplca_txop_table_upd,
        input  txop_claim_table_unpacked,
        input  max_id,
        input  dplca_conflict,
        output local_nodeID,
        output dplca_txop_claim,
        output sel_state,
        output scan_fail
    );
endinterface

// File: rtl/dplca_txop_select.sv
// DPLCA TXOP selector: on table updates, finds the lowest free TXOP ID, claims it
// SOFT, and promotes it to HARD after SETTLE_UPDS quiet updates.
module dplca_txop_select #(
    parameter int          SETTLE_UPDS   = 4,
    parameter logic [7:0]  UNASSIGNED_ID = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    dplca_txop_select_if.slave   bus
);

    localparam logic [1:0] CLAIM_SOFT = 2'b00;
    localparam logic [1:0] CLAIM_HARD = 2'b01;
    localparam logic [1:0] CLAIM_NONE = 2'b10;
    localparam logic [7:0] MAX_SCAN_ID = 8'd254;

    typedef enum logic [2:0] {
        ST_UNASSIGNED = 3'd0,
        ST_SCAN       = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_ASSIGNED   = 3'd3
    } state_t;

    state_t     state_reg;
    logic [7:0] node_id_reg;
    logic [1:0] claim_reg;
    logic       scan_fail_reg;
    logic [3:0] settle_cnt_reg;
    logic [7:0] scan_idx_reg;
    logic       upd_d_reg;

    logic [1:0] table_entry [256];
    logic       upd_event;
    logic [7:0] max_clamped;
    logic [1:0] idx_entry;
    logic [1:0] own_entry;
    logic [3:0] settle_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_unpack
            assign table_entry[gi] = bus.txop_claim_table_unpacked[2*gi+1 : 2*gi];
        end
    endgenerate

    assign upd_event       = bus.dplca_txop_table_upd & ~upd_d_reg;
    assign max_clamped     = (bus.max_id > MAX_SCAN_ID) ? MAX_SCAN_ID : bus.max_id;
    assign idx_entry       = table_entry[scan_idx_reg];
    assign own_entry       = table_entry[node_id_reg];
    assign settle_cnt_next = settle_cnt_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_UNASSIGNED;
            node_id_reg    <= UNASSIGNED_ID;
            claim_reg      <= CLAIM_NONE;
            scan_fail_reg  <= 1'b0;
            settle_cnt_reg <= 4'd0;
            scan_idx_reg   <= 8'd1;
            upd_d_reg      <= 1'b0;
        end else if (!bus.dplca_en) begin
            // Keep following the update level so re-enabling does not fake an edge.
            state_reg      <= ST_UNASSIGNED;
            node_id_reg    <= UNASSIGNED_ID;
            claim_reg      <= CLAIM_NONE;
            scan_fail_reg  <= 1'b0;
            settle_cnt_reg <= 4'd0;
            scan_idx_reg   <= 8'd1;
            upd_d_reg      <= bus.dplca_txop_table_upd;
        end else begin
            upd_d_reg     <= bus.dplca_txop_table_upd;
            scan_fail_reg <= 1'b0;
            case (state_reg)
                ST_UNASSIGNED: begin
                    if (upd_event) begin
                        state_reg    <= ST_SCAN;
                        scan_idx_reg <= 8'd1;
                    end
                end
                ST_SCAN: begin
                    // ID 0 belongs to the coordinator; the scan starts at 1.
                    if (max_clamped == 8'd0) begin
                        state_reg     <= ST_UNASSIGNED;
                        scan_fail_reg <= 1'b1;
                        scan_idx_reg  <= 8'd1;
                    end else if (idx_entry == CLAIM_NONE) begin
                        state_reg      <= ST_SETTLE;
                        node_id_reg    <= scan_idx_reg;
                        claim_reg      <= CLAIM_SOFT;
                        settle_cnt_reg <= 4'd0;
                        scan_idx_reg   <= 8'd1;
                    end else if (scan_idx_reg >= max_clamped) begin
                        state_reg     <= ST_UNASSIGNED;
                        scan_fail_reg <= 1'b1;
                        scan_idx_reg  <= 8'd1;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (bus.dplca_conflict || (upd_event && own_entry == CLAIM_HARD)) begin
                        state_reg      <= ST_UNASSIGNED;
                        node_id_reg    <= UNASSIGNED_ID;
                        claim_reg      <= CLAIM_NONE;
                        settle_cnt_reg <= 4'd0;
                    end else if (upd_event) begin
                        settle_cnt_reg <= settle_cnt_next;
                        if (settle_cnt_next == 4'(SETTLE_UPDS)) begin
                            state_reg <= ST_ASSIGNED;
                            claim_reg <= CLAIM_HARD;
                        end
                    end
                end
                ST_ASSIGNED: begin
                    // Our own HARD claim is in the table, so only a conflict drops it.
                    if (bus.dplca_conflict) begin
                        state_reg      <= ST_UNASSIGNED;
                        node_id_reg    <= UNASSIGNED_ID;
                        claim_reg      <= CLAIM_NONE;
                        settle_cnt_reg <= 4'd0;
                    end
                end
                default: begin
                    state_reg   <= ST_UNASSIGNED;
                    node_id_reg <= UNASSIGNED_ID;
                    claim_reg   <= CLAIM_NONE;
                end
            endcase
        end
    end

    assign bus.local_nodeID     = node_id_reg;
    assign bus.dplca_txop_claim = claim_reg;
    assign bus.sel_state        = state_reg;
    assign bus.scan_fail        = scan_fail_reg;

endmodule

// File: tb/tb_dplca_txop_select.sv
// Scenario bench for dplca_txop_select: expected output snapshots are queued as
// stimulus is applied and compared when the DUT reaches the observed point.
module tb_dplca_txop_select;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] claim;
        logic [2:0] st;
        logic       fail;
    } obs_t;

    localparam logic [1:0] SOFT = 2'b00;
    localparam logic [1:0] HARD = 2'b01;
    localparam logic [1:0] NONE = 2'b10;

    logic clk;
    logic reset;
    logic [1:0] tbl [256];
    obs_t exp_q [$];
    obs_t want;
    obs_t got;
    int   errors;
    int   checks;

    dplca_txop_select_if bus ();

    dplca_txop_select #(.SETTLE_UPDS(4), .UNASSIGNED_ID(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.txop_claim_table_unpacked = '0;
        for (int i = 0; i < 256; i++)
            bus.txop_claim_table_unpacked[2*i +: 2] = tbl[i];
    end

    function automatic obs_t observe();
        return {bus.local_nodeID, bus.dplca_txop_claim, bus.sel_state, bus.scan_fail};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_edge();
        bus.dplca_txop_table_upd = 1'b0;
        tick();
        bus.dplca_txop_table_upd = 1'b1;
    endtask

    task automatic wait_leave_scan(input int budget);
        for (int i = 0; i < budget && bus.sel_state != 3'd2 && !(bus.sel_state == 3'd0 && bus.scan_fail); i++)
            tick();
    endtask

    task automatic test_reset();
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_state got=%h required=%h", got, want); end
        reset = 1'b0;
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        tick(); tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL idle_after_reset got=%h required=%h", got, want); end
        $display("test_reset: checked reset and idle state");
    endtask

    task automatic test_first_scan();
        for (int i = 1; i <= 3; i++) tbl[i] = HARD;
        tbl[4] = NONE;
        bus.max_id = 8'd8;
        exp_q.push_back('{8'hFF, NONE, 3'd1, 1'b0});
        exp_q.push_back('{8'd4, SOFT, 3'd2, 1'b0});
        bus.dplca_txop_table_upd = 1'b1;
        repeat (4) tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL scan_t_plus_4 got=%h required=%h", got, want); end
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL claim_t_plus_5 got=%h required=%h", got, want); end
        $display("test_first_scan: id=%0d claim=%0d state=%0d", bus.local_nodeID, bus.dplca_txop_claim, bus.sel_state);
    endtask

    task automatic test_settle_promote();
        tbl[4] = SOFT;
        for (int n = 1; n <= 5; n++) begin
            if (n >= 4) exp_q.push_back('{8'd4, HARD, 3'd3, 1'b0});
            else        exp_q.push_back('{8'd4, SOFT, 3'd2, 1'b0});
            upd_edge();
            tick();
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL settle_edge_%0d got=%h required=%h", n, got, want); end
            $display("test_settle_promote: edge %0d state=%0d claim=%0d", n, bus.sel_state, bus.dplca_txop_claim);
        end
    endtask

    task automatic test_scan_fail();
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        bus.dplca_conflict = 1'b1;
        tick();
        bus.dplca_conflict = 1'b0;
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL assigned_conflict got=%h required=%h", got, want); end
        for (int i = 1; i <= 8; i++) tbl[i] = (i % 2) ? HARD : SOFT;
        tbl[9] = NONE;
        exp_q.push_back('{8'hFF, NONE, 3'd1, 1'b0});
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b1});
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        upd_edge();
        repeat (8) tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL scan_at_max got=%h required=%h", got, want); end
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL scan_fail_pulse got=%h required=%h", got, want); end
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL scan_fail_clear got=%h required=%h", got, want); end
        $display("test_scan_fail: scan_fail pulse checked");
    endtask

    task automatic test_conflict_abandon();
        for (int i = 1; i <= 8; i++) tbl[i] = HARD;
        tbl[4] = NONE;
        tbl[5] = NONE;
        exp_q.push_back('{8'd4, SOFT, 3'd2, 1'b0});
        upd_edge();
        tick();
        wait_leave_scan(20);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL settle_on_4 got=%h required=%h", got, want); end
        tbl[4] = HARD;
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        bus.dplca_txop_table_upd = 1'b0;
        tick();
        bus.dplca_txop_table_upd = 1'b1;
        bus.dplca_conflict = 1'b1;
        tick();
        bus.dplca_conflict = 1'b0;
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL conflict_abandon got=%h required=%h", got, want); end
        exp_q.push_back('{8'd5, SOFT, 3'd2, 1'b0});
        upd_edge();
        tick();
        wait_leave_scan(20);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL rescan_next_free got=%h required=%h", got, want); end
        tbl[5] = HARD;
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        upd_edge();
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL hard_claim_abandon got=%h required=%h", got, want); end
        $display("test_conflict_abandon: abandon and rescan checked");
    endtask

    task automatic test_enable_drop();
        tbl[5] = NONE;
        exp_q.push_back('{8'hFF, NONE, 3'd1, 1'b0});
        upd_edge();
        repeat (3) tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL mid_scan got=%h required=%h", got, want); end
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        bus.dplca_en = 1'b0;
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL disable_mid_scan got=%h required=%h", got, want); end
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b0});
        bus.dplca_en = 1'b1;
        repeat (3) tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL no_false_edge got=%h required=%h", got, want); end
        exp_q.push_back('{8'hFF, NONE, 3'd1, 1'b0});
        exp_q.push_back('{8'd5, SOFT, 3'd2, 1'b0});
        upd_edge();
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL rescan_after_enable got=%h required=%h", got, want); end
        wait_leave_scan(20);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL claim_after_enable got=%h required=%h", got, want); end
        $display("test_enable_drop: enable drop and restore checked");
    endtask

    task automatic test_max_clamp();
        bus.dplca_conflict = 1'b1;
        tick();
        bus.dplca_conflict = 1'b0;
        for (int i = 1; i <= 253; i++) tbl[i] = HARD;
        tbl[254] = NONE;
        tbl[255] = NONE;
        bus.max_id = 8'd255;
        exp_q.push_back('{8'd254, SOFT, 3'd2, 1'b0});
        upd_edge();
        tick();
        wait_leave_scan(300);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL clamp_pick_254 got=%h required=%h", got, want); end
        bus.dplca_conflict = 1'b1;
        tick();
        bus.dplca_conflict = 1'b0;
        tbl[254] = HARD;
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b1});
        upd_edge();
        tick();
        wait_leave_scan(300);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL clamp_no_255 got=%h required=%h", got, want); end
        bus.max_id = 8'd0;
        exp_q.push_back('{8'hFF, NONE, 3'd1, 1'b0});
        exp_q.push_back('{8'hFF, NONE, 3'd0, 1'b1});
        upd_edge();
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL max0_scan got=%h required=%h", got, want); end
        tick();
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL max0_fail got=%h required=%h", got, want); end
        $display("test_max_clamp: clamp and max_id=0 checked");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) tbl[i] = HARD;
        reset = 1'b1;
        bus.dplca_en = 1'b1;
        bus.dplca_txop_table_upd = 1'b0;
        bus.dplca_conflict = 1'b0;
        bus.max_id = 8'd8;
        repeat (3) tick();
        test_reset();
        test_first_scan();
        test_settle_promote();
        test_scan_fail();
        test_conflict_abandon();
        test_enable_drop();
        test_max_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dplca_txop_select.md
Name: dplca_txop_select

Overview:
- Reader/consumer of the DPLCA TXOP claim table that the aging state machine maintains.
- On each table-update notification, it evaluates the table and, when the local node holds no valid TXOP, scans for the lowest free TXOP ID. It claims that ID SOFT, then promotes the claim to HARD after a settling period.
- It drops the claim on conflict or when DPLCA is disabled.
- It sits between the aging block and the PLCA control/transmit logic, which use local_nodeID and dplca_txop_claim.

Parameters:
- SETTLE_UPDS, 4, number of table-update events without conflict needed to promote SOFT to HARD (1..15).
- UNASSIGNED_ID, 8'hFF, local_nodeID value meaning "no TXOP held".

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- dplca_en  input  1  DPLCA enable; low forces the UNASSIGNED state.
- dplca_txop_table_upd  input  1  level from the aging block; its rising edge is one update event.
- txop_claim_table_unpacked  input  512  256 entries × 2 bits; entry i is at bits [2i+1:2i]. Encoding: SOFT=2'b00, HARD=2'b01, NONE=2'b10, 2'b11 = invalid (treated as claimed).
- max_id  input  8  highest TXOP ID to scan; values above 254 are clamped to 254.
- dplca_conflict  input  1  one-cycle pulse: another node transmitted in the local TXOP.
- local_nodeID  output  8  selected TXOP ID, or UNASSIGNED_ID.
- dplca_txop_claim  output  2  current local claim (SOFT/HARD/NONE).
- sel_state  output  3  state: UNASSIGNED=0, SCAN=1, SETTLE=2, ASSIGNED=3.
- scan_fail  output  1  one-cycle pulse when a scan finds no free ID.

Behaviour:
Reset and enable
- Reset (dominant) gives: local_nodeID=8'hFF, dplca_txop_claim=NONE, sel_state=UNASSIGNED, scan_fail=0, settle counter=0, scan index=1, upd_d=0.
- dplca_en=0 (when not in reset): same values as reset, from any state, including mid-scan.
- The upd_d register still tracks dplca_txop_table_upd while disabled, so no false edge is seen when enable returns.

Update events
- An update event is upd & ~upd_d in a cycle.
- Events arriving while in SCAN are ignored (not queued).

UNASSIGNED
- On an update event: go to SCAN with index=1.

SCAN
- One entry is examined per cycle. ID 0 is reserved for the coordinator and is never scanned.
- Entry at index is NONE: next cycle local_nodeID=index, claim=SOFT, settle counter=0, state SETTLE.
- Entry is not NONE and index==clamped max_id, or clamped max_id==0: next cycle scan_fail=1 for one cycle, state UNASSIGNED, outputs stay at their reset values.
- Otherwise index increments by 1. The index never wraps past 254.
- Latency: if the event occurs in cycle t and the first free ID is k, the new outputs are visible in cycle t+k+1.

SETTLE
- dplca_conflict=1: go to UNASSIGNED, local_nodeID=FF, claim=NONE.
- Update event with table[local_nodeID]==HARD (another node hard-claimed the ID): same abandon as a conflict.
- Update event with no abandon condition: the settle counter increments.
- When the counter reaches SETTLE_UPDS: claim=HARD, state ASSIGNED, on the same edge.
- A conflict in the same cycle as an update event takes priority (abandon).

ASSIGNED
- Holds local_nodeID and claim=HARD.
- dplca_conflict=1: go to UNASSIGNED with NONE/FF; a rescan happens on the next update event.
- The table contents are not re-checked here, because the aging block records the local HARD claim itself.

General
- scan_fail is asserted only in the single cycle described above.
- All outputs are registered.

Test Plan:
1. Reset, dplca_en=1, max_id=8, table entries 1–3 HARD and 4 NONE, upd rises in cycle t. Required: local_nodeID=4, claim=SOFT, sel_state=2 in cycle t+5.
2. From scenario 1, four more upd rising edges with entry 4 remaining SOFT. Required: claim=HARD and sel_state=3 right after the 4th edge; a 5th edge causes no change.
3. Entries 1–8 all HARD/SOFT, max_id=8, upd edge. Required: scan_fail pulses exactly one cycle; local_nodeID stays 8'hFF; state returns to 0.
4. In SETTLE on ID 4, table[4] is set to HARD and upd rises in the same cycle as a dplca_conflict pulse. Required: next cycle local_nodeID=FF, claim=NONE; the next upd edge rescans and picks the next free ID.
5. dplca_en dropped mid-scan at index 3 with upd held high; enable restored. Required: reset values immediately; no scan starts until upd falls and rises again.
6. max_id=255 with only entry 254 NONE. Required: local_nodeID=254 (clamped); max_id=0 yields scan_fail on the cycle after the edge.
